bs_result_stage: RTL and testbench

//  Registered output stage directly downstream of the combinational barrelshifter.

---
 rtl/bs_pkg.sv | 21 ++
 rtl/bs_skid_buffer.sv | 86 ++++++++
 rtl/bs_result_stage.sv | 82 ++++++++
 tb/tb_bs_result_stage.sv | 308 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bs_pkg.sv
// Shared types for the barrelshifter result stage.
// Payload layout and skid-buffer occupancy states.
package bs_pkg;

  localparam int BS_D_SIZE = 4;

  typedef struct packed {
    logic [BS_D_SIZE-1:0] y;
    logic                 zf;
    logic                 vf;
  } bs_result_t;

  localparam int BS_RESULT_W = $bits(bs_result_t);

  typedef enum logic [1:0] {
    BS_EMPTY,
    BS_ONE,
    BS_FULL
  } bs_state_t;

endpackage

// File: rtl/bs_skid_buffer.sv
// Two-entry skid buffer, generic over payload width.
// HEAD drives the outputs; ready is registered to break the ready path.
module bs_skid_buffer
  import bs_pkg::*;
#(
  parameter int W = BS_RESULT_W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] in_data,
  input  logic         in_valid,
  output logic         in_ready,
  output logic [W-1:0] out_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic         push,
  output logic         pop
);

  bs_state_t    state;
  bs_state_t    state_nxt;
  logic [W-1:0] head;
  logic [W-1:0] skid;
  logic         ready_q;
  logic         head_ld;
  logic         head_from_skid;
  logic         skid_ld;

  assign in_ready  = ready_q;
  assign out_valid = (state != BS_EMPTY);
  assign out_data  = head;
  assign push      = in_valid & ready_q;
  assign pop       = out_valid & out_ready;

  always_comb begin
    state_nxt      = state;
    head_ld        = 1'b0;
    head_from_skid = 1'b0;
    skid_ld        = 1'b0;
    unique case (state)
      BS_EMPTY: begin
        if (push) begin
          head_ld   = 1'b1;
          state_nxt = BS_ONE;
        end
      end
      BS_ONE: begin
        if (push && pop) begin
          head_ld = 1'b1;
        end else if (push) begin
          skid_ld   = 1'b1;
          state_nxt = BS_FULL;
        end else if (pop) begin
          state_nxt = BS_EMPTY;
        end
      end
      BS_FULL: begin
        if (pop) begin
          head_ld        = 1'b1;
          head_from_skid = 1'b1;
          state_nxt      = BS_ONE;
        end
      end
      default: state_nxt = BS_EMPTY;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= BS_EMPTY;
      ready_q <= 1'b1;
      head    <= '0;
      skid    <= '0;
    end else begin
      state   <= state_nxt;
      ready_q <= (state_nxt != BS_FULL);
      if (head_ld) begin
        head <= head_from_skid ? skid : in_data;
      end
      if (skid_ld) begin
        skid <= in_data;
      end
    end
  end

endmodule

// File: rtl/bs_result_stage.sv
// Registered output stage behind the barrelshifter.
// Skid-buffered handshake plus sticky overflow and delivered-result count.
module bs_result_stage
  import bs_pkg::*;
#(
  parameter int D_SIZE = BS_D_SIZE,
  parameter int CNT_W  = 8
) (
  input  logic              clk_in,
  input  logic              rst_n_in,
  input  logic [D_SIZE-1:0] y_in,
  input  logic              zf_in,
  input  logic              vf_in,
  input  logic              valid_in,
  output logic              ready_out,
  output logic [D_SIZE-1:0] y_out,
  output logic              zf_out,
  output logic              vf_out,
  output logic              valid_out,
  input  logic              ready_in,
  output logic              vf_sticky_out,
  input  logic              clr_sticky_in,
  output logic [CNT_W-1:0]  result_count_out
);

  // Same layout as bs_result_t, sized by this instance's D_SIZE.
  typedef struct packed {
    logic [D_SIZE-1:0] y;
    logic              zf;
    logic              vf;
  } result_t;

  localparam int RW = $bits(result_t);

  result_t          in_res;
  result_t          out_res;
  logic             push;
  logic             pop;
  logic             sticky;
  logic [CNT_W-1:0] count;

  assign in_res = '{y: y_in, zf: zf_in, vf: vf_in};

  bs_skid_buffer #(
    .W (RW)
  ) u_skid (
    .clk       (clk_in),
    .rst_n     (rst_n_in),
    .in_data   (in_res),
    .in_valid  (valid_in),
    .in_ready  (ready_out),
    .out_data  (out_res),
    .out_valid (valid_out),
    .out_ready (ready_in),
    .push      (push),
    .pop       (pop)
  );

  assign y_out            = out_res.y;
  assign zf_out           = out_res.zf;
  assign vf_out           = out_res.vf;
  assign vf_sticky_out    = sticky;
  assign result_count_out = count;

  // A set in the same cycle as a clear wins.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      sticky <= 1'b0;
    end else begin
      sticky <= (sticky & ~clr_sticky_in) | (push & vf_in);
    end
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      count <= '0;
    end else if (pop && (count != '1)) begin
      count <= count + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_bs_result_stage.sv
// Scoreboard bench for bs_result_stage.
// Two instances: 8-bit counter and 3-bit saturating counter.
module tb_bs_result_stage;

  logic       clk = 1'b0;
  logic       rst_n_in = 1'b0;
  logic [3:0] y_in = '0;
  logic       zf_in = 1'b0;
  logic       vf_in = 1'b0;
  logic       valid_in = 1'b0;
  logic       ready_in = 1'b0;
  logic       clr_sticky_in = 1'b0;

  logic       ready_out, zf_out, vf_out, valid_out, vf_sticky_out;
  logic [3:0] y_out;
  logic [7:0] result_count_out;

  logic       s_ready_out, s_zf_out, s_vf_out, s_valid_out, s_sticky;
  logic [3:0] s_y_out;
  logic [2:0] s_count;

  int n_checks = 0;
  int n_fail = 0;
  int n_pop = 0;

  logic [5:0] sb[$];
  logic [5:0] exp_r;
  logic       pop_now;

  always #5 clk = ~clk;

  bs_result_stage #(.D_SIZE(4), .CNT_W(8)) dut (
    .clk_in           (clk),
    .rst_n_in         (rst_n_in),
    .y_in             (y_in),
    .zf_in            (zf_in),
    .vf_in            (vf_in),
    .valid_in         (valid_in),
    .ready_out        (ready_out),
    .y_out            (y_out),
    .zf_out           (zf_out),
    .vf_out           (vf_out),
    .valid_out        (valid_out),
    .ready_in         (ready_in),
    .vf_sticky_out    (vf_sticky_out),
    .clr_sticky_in    (clr_sticky_in),
    .result_count_out (result_count_out)
  );

  bs_result_stage #(.D_SIZE(4), .CNT_W(3)) dut_s (
    .clk_in           (clk),
    .rst_n_in         (rst_n_in),
    .y_in             (y_in),
    .zf_in            (zf_in),
    .vf_in            (vf_in),
    .valid_in         (valid_in),
    .ready_out        (s_ready_out),
    .y_out            (s_y_out),
    .zf_out           (s_zf_out),
    .vf_out           (s_vf_out),
    .valid_out        (s_valid_out),
    .ready_in         (ready_in),
    .vf_sticky_out    (s_sticky),
    .clr_sticky_in    (clr_sticky_in),
    .result_count_out (s_count)
  );

  // Drive one cycle of stimulus and record the handshakes it will make.
  task automatic drive(input logic v, input logic [3:0] y,
                       input logic z, input logic f,
                       input logic r, input logic c);
    @(posedge clk);
    #1;
    valid_in      = v;
    y_in          = y;
    zf_in         = z;
    vf_in         = f;
    ready_in      = r;
    clr_sticky_in = c;
    @(negedge clk);
    pop_now = valid_out & ready_in;
    if (valid_in && ready_out) sb.push_back({y, z, f});
  endtask

  task automatic test_reset;
    rst_n_in = 1'b0;
    valid_in = 1'b1;
    y_in     = 4'hF;
    vf_in    = 1'b1;
    ready_in = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_checks++;
    if ({valid_out, ready_out, vf_sticky_out, result_count_out} !== {3'b010, 8'd0}) begin
      n_fail++;
      $display("FAIL reset: got v=%b r=%b s=%b c=%0d expected v=0 r=1 s=0 c=0",
               valid_out, ready_out, vf_sticky_out, result_count_out);
    end
    n_checks++;
    if ({s_valid_out, s_ready_out, s_sticky, s_count} !== {3'b010, 3'd0}) begin
      n_fail++;
      $display("FAIL reset_sat: got v=%b r=%b s=%b c=%0d expected v=0 r=1 s=0 c=0",
               s_valid_out, s_ready_out, s_sticky, s_count);
    end
    valid_in = 1'b0;
    vf_in    = 1'b0;
    ready_in = 1'b0;
    rst_n_in = 1'b1;
    sb.delete();
  endtask

  task automatic test_pass_through;
    test_reset();
    drive(1'b1, 4'b1010, 1'b0, 1'b1, 1'b1, 1'b0);
    drive(1'b0, 4'b0000, 1'b0, 1'b0, 1'b1, 1'b0);
    n_checks++;
    if ({valid_out, vf_sticky_out} !== 2'b11) begin
      n_fail++;
      $display("FAIL pass_valid_sticky: got v=%b s=%b expected v=1 s=1",
               valid_out, vf_sticky_out);
    end
    n_checks++;
    if (!pop_now || sb.size() == 0) begin
      n_fail++;
      $display("FAIL pass_pop: got pop=%b q=%0d expected pop=1 q=1",
               pop_now, sb.size());
    end else begin
      exp_r = sb.pop_front();
      n_checks++;
      if ({y_out, zf_out, vf_out} !== exp_r) begin
        n_fail++;
        $display("FAIL pass_data: got %b expected %b", {y_out, zf_out, vf_out}, exp_r);
      end
    end
    drive(1'b0, 4'b0000, 1'b0, 1'b0, 1'b1, 1'b0);
    n_checks++;
    if ({valid_out, result_count_out} !== {1'b0, 8'd1}) begin
      n_fail++;
      $display("FAIL pass_count: got v=%b c=%0d expected v=0 c=1",
               valid_out, result_count_out);
    end
  endtask

  task automatic test_backpressure;
    test_reset();
    drive(1'b1, 4'b0001, 1'b0, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 4'b0010, 1'b0, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 4'b0011, 1'b0, 1'b0, 1'b0, 1'b0);
    n_checks++;
    if (ready_out !== 1'b0 || sb.size() != 2) begin
      n_fail++;
      $display("FAIL bp_full: got ready=%b q=%0d expected ready=0 q=2",
               ready_out, sb.size());
    end
    drive(1'b1, 4'b0011, 1'b0, 1'b0, 1'b0, 1'b0);
    n_checks++;
    if ({valid_out, y_out} !== {1'b1, 4'b0001}) begin
      n_fail++;
      $display("FAIL bp_hold: got v=%b y=%b expected v=1 y=0001", valid_out, y_out);
    end
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 4'b0000, 1'b0, 1'b0, 1'b1, 1'b0);
      if (i == 1) begin
        n_checks++;
        if (ready_out !== 1'b1) begin
          n_fail++;
          $display("FAIL bp_ready: got %b expected 1", ready_out);
        end
      end
      if (pop_now) begin
        n_checks++;
        if (sb.size() == 0) begin
          n_fail++;
          $display("FAIL bp_extra: got pop expected none");
        end else begin
          exp_r = sb.pop_front();
          if ({y_out, zf_out, vf_out} !== exp_r) begin
            n_fail++;
            $display("FAIL bp_data: got %b expected %b", {y_out, zf_out, vf_out}, exp_r);
          end
        end
      end
    end
    n_checks++;
    if (sb.size() != 0 || result_count_out !== 8'd2) begin
      n_fail++;
      $display("FAIL bp_drain: got q=%0d c=%0d expected q=0 c=2",
               sb.size(), result_count_out);
    end
  endtask

  task automatic stream(input int n);
    logic [3:0] y;
    n_pop = 0;
    for (int i = 0; i < n + 2; i++) begin
      y = 4'(i);
      if (i < n) drive(1'b1, y, (y == 4'd0), y[0], 1'b1, 1'b0);
      else drive(1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0);
      if (i < n) begin
        n_checks++;
        if (ready_out !== 1'b1) begin
          n_fail++;
          $display("FAIL stream_ready: got %b expected 1 at %0d", ready_out, i);
        end
      end
      if (i > 0 && i <= n) begin
        n_checks++;
        if (pop_now !== 1'b1) begin
          n_fail++;
          $display("FAIL stream_rate: got pop=%b expected 1 at %0d", pop_now, i);
        end
      end
      if (pop_now) begin
        n_pop++;
        n_checks++;
        if (sb.size() == 0) begin
          n_fail++;
          $display("FAIL stream_extra: got pop expected none");
        end else begin
          exp_r = sb.pop_front();
          if ({y_out, zf_out, vf_out} !== exp_r) begin
            n_fail++;
            $display("FAIL stream_data: got %b expected %b", {y_out, zf_out, vf_out}, exp_r);
          end
        end
      end
    end
    n_checks++;
    if (n_pop != n || valid_out !== 1'b0) begin
      n_fail++;
      $display("FAIL stream_total: got pops=%0d v=%b expected pops=%0d v=0",
               n_pop, valid_out, n);
    end
  endtask

  task automatic test_back_to_back;
    test_reset();
    stream(16);
    n_checks++;
    if (result_count_out !== 8'd16) begin
      n_fail++;
      $display("FAIL b2b_count: got %0d expected 16", result_count_out);
    end
  endtask

  task automatic test_sticky;
    test_reset();
    drive(1'b1, 4'b0100, 1'b0, 1'b1, 1'b1, 1'b1);
    drive(1'b0, 4'b0000, 1'b0, 1'b0, 1'b1, 1'b1);
    n_checks++;
    if (vf_sticky_out !== 1'b1) begin
      n_fail++;
      $display("FAIL sticky_set_wins: got %b expected 1", vf_sticky_out);
    end
    if (pop_now && sb.size() != 0) exp_r = sb.pop_front();
    drive(1'b0, 4'b0000, 1'b0, 1'b0, 1'b1, 1'b0);
    n_checks++;
    if (vf_sticky_out !== 1'b0) begin
      n_fail++;
      $display("FAIL sticky_clear: got %b expected 0", vf_sticky_out);
    end
  endtask

  task automatic test_saturation_reset;
    test_reset();
    stream(10);
    n_checks++;
    if (s_count !== 3'd7 || result_count_out !== 8'd10) begin
      n_fail++;
      $display("FAIL sat_count: got s=%0d c=%0d expected s=7 c=10",
               s_count, result_count_out);
    end
    drive(1'b1, 4'b1100, 1'b0, 1'b1, 1'b0, 1'b0);
    drive(1'b1, 4'b1101, 1'b0, 1'b0, 1'b0, 1'b0);
    drive(1'b0, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0);
    n_checks++;
    if (ready_out !== 1'b0 || s_ready_out !== 1'b0) begin
      n_fail++;
      $display("FAIL sat_full: got r=%b sr=%b expected 0 0", ready_out, s_ready_out);
    end
    #2;
    rst_n_in = 1'b0;
    #1;
    n_checks++;
    if ({valid_out, ready_out, vf_sticky_out, result_count_out, s_count}
        !== {3'b010, 8'd0, 3'd0}) begin
      n_fail++;
      $display("FAIL async_reset: got v=%b r=%b s=%b c=%0d sc=%0d expected v=0 r=1 s=0 c=0 sc=0",
               valid_out, ready_out, vf_sticky_out, result_count_out, s_count);
    end
    sb.delete();
    @(negedge clk);
    rst_n_in = 1'b1;
  endtask

  initial begin
    test_reset();
    test_pass_through();
    test_backpressure();
    test_back_to_back();
    test_sticky();
    test_saturation_reset();
    repeat (2) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
